// File: rtl/fifo_uart_pkg.sv
// Shared types, ASCII constants and helpers for the FIFO-to-UART hex dumper.
// Contents:
//   tx_state_e      - FSM state encoding used by the popper and the serialiser
//   char_sel_e      - which character the popper hands over (hex digit, CR or LF)
//   ASCII_*         - ASCII constants for digits, letters and line endings
//   nibble_to_ascii - 4-bit value to its upper-case ASCII hex character
//   line_end_char   - CR or LF byte
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLatch,
    StStart,
    StData,
    StStop
  } tx_state_e;

  typedef enum logic [1:0] {
    SelHex,
    SelCr,
    SelLf
  } char_sel_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;  // 'A' - 10
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return ((nib < 4'd10) ? ASCII_0 : ASCII_A_OFS) + {4'b0000, nib};
  endfunction

  function automatic logic [7:0] line_end_char(input logic is_lf);
    return is_lf ? ASCII_LF : ASCII_CR;
  endfunction

endpackage

// File: rtl/fifo_hex_uart_tx_if.sv
// FIFO read-port bundle between a FIFO and its reader.
// Signals:
//   fifo_rd_en   - single-cycle pop request from the reader
//   fifo_rd_data - 4-bit entry, valid the cycle after fifo_rd_en
//   fifo_empty   - registered empty flag from the FIFO
// Modports: master = reader side, slave = FIFO side.
interface fifo_hex_uart_tx_if;

  logic       fifo_rd_en;
  logic [3:0] fifo_rd_data;
  logic       fifo_empty;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty
  );

endinterface

// File: rtl/fifo_hex_uart_tx_uart_tx_8n1.sv
// 8N1 UART serialiser. A start strobe in idle loads the byte; the frame is one
// low start bit, eight data bits LSB first and one high stop bit, each
// CLKS_PER_BIT cycles long.
// Ports:
//   clk, rst - clock, asynchronous active-low reset
//   start    - load strobe, honoured only when idle
//   data     - byte to send
//   tx       - registered serial output, idle high
//   busy     - high from the first start-bit cycle to the last stop-bit cycle
//   done     - single-cycle pulse on the last stop-bit cycle
module uart_tx_8n1
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, busy_q, done_q;
  logic            bit_last;

  assign bit_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          shift_d = data;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so tx never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= (state_d == StStart) ? 1'b0 : (state_d == StData) ? shift_d[0] : 1'b1;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StStop) && (cnt_d == CntLast);
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/fifo_hex_uart_tx.sv
// Drains a 4-bit FIFO one entry at a time and sends each entry as an ASCII hex
// character in an 8N1 UART frame.
// Optional feature macro: HEX_TX_CRLF_EN - after every LINE_LEN hex characters
// a CR and LF pair is sent without popping the FIFO.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   enable    - level; gates only the idle-to-pop decision
//   fifo      - FIFO read port (master side: fifo_rd_en out, data/empty in)
//   tx        - UART serial out, idle high
//   busy      - high from the pop cycle to the end of the stop bit
//   char_done - single-cycle pulse on the last stop-bit cycle of each character
module fifo_hex_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned LINE_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  fifo_hex_uart_tx_if.master        fifo,
  output logic                      tx,
  output logic                      busy,
  output logic                      char_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  if (CLKS_PER_BIT < 2 || LINE_LEN < 1) begin : g_bad_cfg
    $error("fifo_hex_uart_tx: need CLK_HZ/BAUD >= 2 and LINE_LEN >= 1");
  end

  tx_state_e  state_q, state_d;
  logic       rd_en_q, pre_busy_q;
  logic       ser_start, ser_busy, ser_done;
  logic [7:0] ser_data;

`ifdef HEX_TX_CRLF_EN
  localparam int unsigned LcW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [LcW-1:0] LcLast = LcW'(LINE_LEN - 1);

  char_sel_e      sel_q, sel_d;
  logic [LcW-1:0] line_cnt_q, line_cnt_d;

  // CR/LF passes through LATCH like a popped entry, but rd_data is ignored.
  assign ser_data = (sel_q == SelHex) ? nibble_to_ascii(fifo.fifo_rd_data)
                                      : line_end_char(sel_q == SelLf);
`else
  assign ser_data = nibble_to_ascii(fifo.fifo_rd_data);
`endif

  always_comb begin
    state_d = state_q;
`ifdef HEX_TX_CRLF_EN
    sel_d      = sel_q;
    line_cnt_d = line_cnt_q;
`endif
    case (state_q)
      StIdle:  if (enable && !fifo.fifo_empty) state_d = StPop;
      StPop:   state_d = StLatch;
      StLatch: state_d = StStart;
      // StStart here means the frame is in flight inside the serialiser.
      StStart: begin
        if (ser_done) begin
`ifdef HEX_TX_CRLF_EN
          case (sel_q)
            SelHex: begin
              if (line_cnt_q == LcLast) begin
                line_cnt_d = '0;
                sel_d      = SelCr;
                state_d    = StLatch;
              end else begin
                line_cnt_d = line_cnt_q + 1'b1;
                state_d    = StIdle;
              end
            end
            SelCr: begin
              sel_d   = SelLf;
              state_d = StLatch;
            end
            default: begin
              sel_d   = SelHex;
              state_d = StIdle;
            end
          endcase
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      pre_busy_q <= 1'b0;
`ifdef HEX_TX_CRLF_EN
      sel_q      <= SelHex;
      line_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_en_q    <= (state_d == StPop);
      pre_busy_q <= (state_d == StPop) || (state_d == StLatch);
`ifdef HEX_TX_CRLF_EN
      sel_q      <= sel_d;
      line_cnt_q <= line_cnt_d;
`endif
    end
  end

  assign ser_start = (state_q == StLatch);

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(ser_start),
    .data (ser_data),
    .tx   (tx),
    .busy (ser_busy),
    .done (ser_done)
  );

  assign fifo.fifo_rd_en = rd_en_q;
  // pre_busy covers POP/LATCH, the serialiser covers START..STOP; they abut.
  assign busy      = pre_busy_q | ser_busy;
  assign char_done = ser_done;

endmodule

// File: tb/tb_fifo_hex_uart_tx.sv
module tb_fifo_hex_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic tx, busy, char_done;

  fifo_hex_uart_tx_if fifo_if ();

  fifo_hex_uart_tx #(
    .CLK_HZ  (16),
    .BAUD    (1),
    .LINE_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .fifo     (fifo_if),
    .tx       (tx),
    .busy     (busy),
    .char_done(char_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int bad_pops = 0;
  int done_cnt = 0;
  int starts = 0;
  int frame_err = 0;
  int tb_line = 0;
  logic [3:0] mem[$];
  logic [3:0] push_req[$];
  logic [7:0] rx[$];
  int         rx_start[$];
  logic [7:0] exp_q[$];

  // Behavioural FIFO with registered rd_data and registered empty flag.
  initial begin
    fifo_if.fifo_empty   = 1'b1;
    fifo_if.fifo_rd_data = 4'h0;
    forever begin
      @(posedge clk);
      cyc++;
      if (fifo_if.fifo_rd_en) begin
        pops++;
        if (fifo_if.fifo_empty || mem.size() == 0) bad_pops++;
        if (mem.size() > 0) fifo_if.fifo_rd_data <= mem.pop_front();
      end
      while (push_req.size() > 0) mem.push_back(push_req.pop_front());
      fifo_if.fifo_empty <= (mem.size() == 0);
    end
  end

  // UART receiver sampling mid-bit, plus char_done counter.
  initial begin
    bit act;
    int n;
    logic prev;
    logic [7:0] sh;
    act = 1'b0;
    n = 0;
    prev = 1'b1;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (char_done) done_cnt++;
      if (!rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (!tx && prev) begin
          act = 1'b1;
          n = 0;
          rx_start.push_back(cyc);
          starts++;
        end
      end else begin
        n++;
        if (n % 16 == 8) begin
          if (n / 16 >= 1 && n / 16 <= 8) begin
            sh = {tx, sh[7:1]};
          end else if (n / 16 == 9) begin
            if (tx) rx.push_back(sh);
            else frame_err++;
            act = 1'b0;
          end
        end
      end
      prev = tx;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic void exp_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = 8'h30 + 8'(nib);
    else c = 8'h41 + 8'(nib) - 8'd10;
    exp_q.push_back(c);
`ifdef HEX_TX_CRLF_EN
    tb_line++;
    if (tb_line == 4) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      tb_line = 0;
    end
`endif
  endfunction

  task automatic push(input logic [3:0] nib);
    push_req.push_back(nib);
    exp_char(nib);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    tb_line = 0;
    rx.delete();
    rx_start.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int need, input int budget);
    int k;
    k = 0;
    while (rx.size() < need && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    int k;
    tick(2);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_if.fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_if.fifo_rd_en);
    end
    checks++; if (char_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", char_done); end
    rst = 1'b1;
    enable = 1'b1;
    tick(20);
    checks++; if (pops !== 0) begin errors++; $display("FAIL empty_no_pop: got %0d pops want 0", pops); end
    // Mid-frame reset.
    push_req.push_back(4'h5);
    k = 0;
    while (!fifo_if.fifo_rd_en && k < 20) begin @(negedge clk); k++; end
    checks++; if (!fifo_if.fifo_rd_en) begin errors++; $display("FAIL reset_pop_seen: got 0 want 1"); end
    tick(40);
    rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (fifo_if.fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL midreset_rd_en: got %b want 0", fifo_if.fifo_rd_en);
    end
    tick(2);
    rst = 1'b1;
    tick(200);
    checks++; if (pops !== 1) begin errors++; $display("FAIL midreset_pops: got %0d want 1", pops); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int k, p0, d0, pc, tc, bad, bad_i;
    logic [9:0] frame;
    logic busy_mid;
    do_reset();
    p0 = pops;
    d0 = done_cnt;
    frame = {1'b1, 8'h41, 1'b0};
    push(4'hA);
    k = 0;
    while (!fifo_if.fifo_rd_en && k < 20) begin @(negedge clk); k++; end
    pc = cyc;
    checks++; if (!fifo_if.fifo_rd_en) begin errors++; $display("FAIL single_pop: got 0 want 1"); end
    k = 0;
    while (tx && k < 10) begin @(negedge clk); k++; end
    tc = cyc;
    checks++; if (tc != pc + 2) begin
      errors++; $display("FAIL single_latency: tx fell at %0d want %0d", tc, pc + 2);
    end
    bad = 0;
    bad_i = -1;
    busy_mid = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 80) busy_mid = busy;
      if (tx !== frame[i/16]) begin
        bad++;
        if (bad_i < 0) bad_i = i;
      end
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL single_frame: %0d bad cycles (first %0d) want 0", bad, bad_i);
    end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_mid); end
    tick(10);
    checks++; if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    checks++; if (done_cnt - d0 != exp_q.size()) begin
      errors++; $display("FAIL single_done: got %0d want %0d", done_cnt - d0, exp_q.size());
    end
    checks++; if (rx.size() != 1 || rx[0] !== 8'h41) begin
      errors++; $display("FAIL single_byte: got %0d bytes first %h want 1 bytes 41", rx.size(),
                         (rx.size() > 0) ? rx[0] : 8'hxx);
    end
  endtask

  task automatic test_digit();
    do_reset();
    push(4'h3);
    push(4'hF);
    wait_rx(2, 600);
    checks++; if (rx.size() < 2) begin errors++; $display("FAIL digit_count: got %0d want 2", rx.size()); end
    checks++; if (rx.size() < 1 || rx[0] !== 8'h33) begin
      errors++; $display("FAIL digit_byte0: got %h want 33", (rx.size() > 0) ? rx[0] : 8'hxx);
    end
    checks++; if (rx.size() < 2 || rx[1] !== 8'h46) begin
      errors++; $display("FAIL digit_byte1: got %h want 46", (rx.size() > 1) ? rx[1] : 8'hxx);
    end
    checks++; if (rx_start.size() < 2 || rx_start[1] - rx_start[0] != 163) begin
      errors++; $display("FAIL digit_spacing: got %0d want 163",
                         (rx_start.size() > 1) ? rx_start[1] - rx_start[0] : -1);
    end
    tick(20);
  endtask

  task automatic test_drain();
    int p0, d0;
    logic [3:0] vals[5];
    vals = '{4'h1, 4'h9, 4'hA, 4'hC, 4'hF};
    do_reset();
    p0 = pops;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) push(vals[i]);
    wait_rx(exp_q.size(), 1500);
    tick(20);
    checks++; if (pops - p0 != 5) begin errors++; $display("FAIL drain_pops: got %0d want 5", pops - p0); end
    checks++; if (done_cnt - d0 != exp_q.size()) begin
      errors++; $display("FAIL drain_done: got %0d want %0d", done_cnt - d0, exp_q.size());
    end
    checks++; if (rx.size() != exp_q.size()) begin
      errors++; $display("FAIL drain_count: got %0d want %0d", rx.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (((i < rx.size()) ? rx[i] : 8'hxx) !== exp_q[i]) begin
        errors++; $display("FAIL drain_byte%0d: got %h want %h", i,
                           (i < rx.size()) ? rx[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (bad_pops != 0) begin errors++; $display("FAIL drain_bad_pop: got %0d want 0", bad_pops); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL drain_framing: got %0d want 0", frame_err); end
  endtask

  task automatic test_enable();
    int p0, d0, s0, k;
    do_reset();
    p0 = pops;
    d0 = done_cnt;
    s0 = starts;
    enable = 1'b1;
    push(4'h6);
    push(4'h7);
    push(4'h8);
    push(4'h9);
    k = 0;
    while (starts < s0 + 2 && k < 500) begin @(negedge clk); k++; end
    tick(40);
    enable = 1'b0;
    k = 0;
    while (done_cnt - d0 < 2 && k < 300) begin @(negedge clk); k++; end
    tick(300);
    checks++; if (pops - p0 != 2) begin errors++; $display("FAIL en_pops_held: got %0d want 2", pops - p0); end
    checks++; if (rx.size() != 2) begin errors++; $display("FAIL en_rx_held: got %0d want 2", rx.size()); end
    checks++; if (mem.size() != 2) begin errors++; $display("FAIL en_fifo_left: got %0d want 2", mem.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
    enable = 1'b1;
    wait_rx(exp_q.size(), 1200);
    tick(20);
    checks++; if (pops - p0 != 4) begin errors++; $display("FAIL en_pops_all: got %0d want 4", pops - p0); end
    checks++; if (rx.size() != exp_q.size()) begin
      errors++; $display("FAIL en_count: got %0d want %0d", rx.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (((i < rx.size()) ? rx[i] : 8'hxx) !== exp_q[i]) begin
        errors++; $display("FAIL en_byte%0d: got %h want %h", i,
                           (i < rx.size()) ? rx[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_crlf();
    logic [7:0] want[$];
`ifdef HEX_TX_CRLF_EN
    want = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h34, 8'h35};
`else
    want = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) push(4'(i));
    wait_rx(want.size(), 2000);
    tick(20);
    checks++; if (rx.size() != want.size()) begin
      errors++; $display("FAIL crlf_count: got %0d want %0d", rx.size(), want.size());
    end
    for (int i = 0; i < want.size(); i++) begin
      checks++;
      if (((i < rx.size()) ? rx[i] : 8'hxx) !== want[i]) begin
        errors++; $display("FAIL crlf_byte%0d: got %h want %h", i,
                           (i < rx.size()) ? rx[i] : 8'hxx, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_digit();
    test_drain();
    test_enable();
    test_crlf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
